dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
- Data-memory responder serving the processor core's data-memory port: captures processor writes (address, data, write enable) and returns registered read data.
- Adds a host-side access port. The host preloads memory before a run, starts the core, and reads results back after the core signals end of program.
- Sits between the processor top and the board-level host/loader logic. Synthesises to block RAM.

Parameters:
- ADDR_W, 12, width of processor and host addresses
- DATA_W, 12, memory word width
- BUS_W, 17, width of the processor data bus; bits above DATA_W-1 are discarded on write
- DEPTH, 256, number of implemented words; addresses >= DEPTH are out of range

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- ar_in  in  ADDR_W  processor data address
- bus_in  in  BUS_W  processor bus, write data source
- dm_en  in  1  processor write enable, registered copy from the core
- end_process  in  1  processor end-of-program flag
- dm_out  out  DATA_W  read data to the processor
- proc_run  out  1  high while the core is allowed to execute
- host_valid  in  1  host request valid
- host_ready  out  1  responder accepts host request
- host_wr  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_rdata  out  DATA_W  host read data
- host_rvalid  out  1  one-cycle pulse, host_rdata valid
- host_go  in  1  start/restart execution pulse
- addr_err  out  1  sticky out-of-range access flag
- wr_count  out  16  processor writes committed in the current run

Behaviour:
- Reset (async, rst_n=0):
  - State goes to LOAD.
  - dm_out=0, proc_run=0, host_ready=0, host_rdata=0, host_rvalid=0, addr_err=0, wr_count=0.
  - Memory contents are not cleared.
- States: LOAD, RUN, HALT.
  - LOAD -> RUN on host_go=1. wr_count clears on this edge.
  - RUN -> HALT on end_process=1.
  - HALT -> RUN on host_go=1. wr_count clears.
  - host_go is ignored while in RUN.
- host_ready is a registered decode of state: 1 in LOAD and HALT, 0 in RUN.
  - It is 0 in the first cycle after reset deassertion, then 1.
- A host transfer occurs on a rising edge with host_valid & host_ready.
  - Write: mem[host_addr] <= host_wdata.
  - Read: host_rdata = mem[host_addr] and host_rvalid=1 on the next edge. host_rvalid is 0 otherwise.
  - Back-to-back reads give one rvalid per accepted request, in order.
- host_go and a host transfer in the same cycle: the transfer completes first, then the state moves to RUN.
  - A read issued in that cycle still produces host_rvalid the following cycle.
- proc_run is registered. It is 1 exactly while the state is RUN.
- In RUN, every edge: dm_out <= mem[ar_in], giving one-cycle read latency.
  - If dm_en=1: mem[ar_in] <= bus_in[DATA_W-1:0]; bus_in[BUS_W-1:DATA_W] is dropped.
  - wr_count increments on each committed write and saturates at 16'hFFFF.
  - Same-address read and write in one cycle is read-first: dm_out shows the old word, and the new word appears next cycle.
- Leaving RUN:
  - A write with dm_en=1 in the same cycle as end_process=1 is committed.
  - dm_en is ignored in LOAD and HALT.
  - dm_out holds its last value outside RUN.
- Out of range: any address >= DEPTH on a processor or host access.
  - The write is suppressed.
  - The read returns 0.
  - addr_err is set and stays set until reset.
- Reset mid-run or mid-host-read: all outputs go to their reset values immediately; any pending rvalid is discarded.

Test Plan:
- Reset then idle: check host_ready=0 for one cycle then 1, proc_run=0, dm_out=0. Host write 0x0A5 to addr 3, read addr 3 -> host_rvalid pulse one cycle later with host_rdata=0x0A5.
- Pulse host_go -> proc_run=1 on the next edge and host_ready=0. With ar_in=3, dm_en=0 -> dm_out=0x0A5 one cycle later.
- RUN, ar_in=5, bus_in=17'h1F123, dm_en=1 -> mem[5]=0x123 and wr_count=1. Same-cycle read of addr 5 shows the old value, the next cycle shows 0x123.
- end_process=1 together with dm_en=1, ar_in=7, bus_in=0x456 -> state HALT, proc_run=0. A host read of addr 7 returns 0x456. dm_en pulses while halted leave memory unchanged.
- Host read of addr 300 (DEPTH=256) -> host_rdata=0 and addr_err=1. addr_err stays 1 after host_go and a clean run; it clears only on reset.
- Assert rst_n=0 during RUN with a read outstanding -> proc_run, host_rvalid, dm_out and wr_count go to 0 asynchronously. The state returns to LOAD, and memory still holds 0x0A5 at addr 3.

Source files
------------

// File: rtl/dm_responder.sv
// dm_responder: data-memory responder for the processor core.
// Serves the core's data-memory port during RUN (registered read data,
// read-first on same-address write) and gives the host a load/readback port
// while the core is stopped (LOAD after reset, HALT after end of program).
// Host and processor accesses never overlap: host_ready is low exactly while
// the state is RUN, so one shared address/write path feeds the memory.
module dm_responder #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12,
  parameter int BUS_W  = 17,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ar_in,
  input  logic [BUS_W-1:0]  bus_in,
  input  logic              dm_en,
  input  logic              end_process,
  output logic [DATA_W-1:0] dm_out,
  output logic              proc_run,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  input  logic              host_go,
  output logic              addr_err,
  output logic [15:0]       wr_count
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              proc_run_q, proc_run_d;
  logic              host_ready_q, host_ready_d;
  logic [DATA_W-1:0] dm_out_q, dm_out_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              host_rvalid_q, host_rvalid_d;
  logic              addr_err_q, addr_err_d;
  logic [15:0]       wr_count_q, wr_count_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_run;
  logic              host_acc;
  logic              host_rd;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_active;
  logic              acc_in_range;
  logic [IDX_W-1:0]  acc_idx;
  logic [DATA_W-1:0] rd_word;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              unused_bus_hi;

  // Upper processor bus bits carry no memory data.
  assign unused_bus_hi = ^bus_in[BUS_W-1:DATA_W];

  assign in_run       = (state_q == ST_RUN);
  assign host_acc     = host_valid & host_ready_q;
  assign host_rd      = host_acc & ~host_wr;
  assign acc_addr     = in_run ? ar_in : host_addr;
  assign acc_active   = in_run | host_acc;
  assign acc_in_range = ({1'b0, acc_addr} < DEPTH_L);
  assign acc_idx      = acc_addr[IDX_W-1:0];
  assign rd_word      = acc_in_range ? mem[acc_idx] : '0;
  assign mem_we       = acc_in_range & (in_run ? dm_en : (host_acc & host_wr));
  assign mem_wdata    = in_run ? bus_in[DATA_W-1:0] : host_wdata;

  // Run-control state machine: next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD, ST_HALT: if (host_go)     state_d = ST_RUN;
      ST_RUN:           if (end_process) state_d = ST_HALT;
      default:                           state_d = ST_LOAD;
    endcase
  end

  // Next values of registered outputs; run/ready decode the next state so
  // they line up with the state register on every edge.
  always_comb begin
    proc_run_d    = (state_d == ST_RUN);
    host_ready_d  = (state_d != ST_RUN);
    dm_out_d      = in_run ? rd_word : dm_out_q;
    host_rdata_d  = host_rd ? rd_word : host_rdata_q;
    host_rvalid_d = host_rd;
    addr_err_d    = addr_err_q | (acc_active & ~acc_in_range);
    wr_count_d    = wr_count_q;
    if (!in_run && host_go) begin
      wr_count_d = '0;
    end else if (in_run && mem_we && (wr_count_q != 16'hFFFF)) begin
      wr_count_d = wr_count_q + 16'd1;
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_LOAD;
      proc_run_q    <= 1'b0;
      host_ready_q  <= 1'b0;
      dm_out_q      <= '0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
      addr_err_q    <= 1'b0;
      wr_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      proc_run_q    <= proc_run_d;
      host_ready_q  <= host_ready_d;
      dm_out_q      <= dm_out_d;
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
      addr_err_q    <= addr_err_d;
      wr_count_q    <= wr_count_d;
    end
  end

  // Memory array: single write port, contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[acc_idx] <= mem_wdata;
    end
  end

  assign dm_out      = dm_out_q;
  assign proc_run    = proc_run_q;
  assign host_ready  = host_ready_q;
  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;
  assign addr_err    = addr_err_q;
  assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_dm_responder.sv
// Testbench for dm_responder: directed scenarios plus a randomized run, all
// checked against a procedural reference model of the responder.
module tb_dm_responder;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 12;
  localparam int BUS_W  = 17;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [ADDR_W-1:0] ar_in = '0;
  logic [BUS_W-1:0]  bus_in = '0;
  logic              dm_en = 1'b0;
  logic              end_process = 1'b0;
  logic [DATA_W-1:0] dm_out;
  logic              proc_run;
  logic              host_valid = 1'b0;
  logic              host_ready;
  logic              host_wr = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [DATA_W-1:0] host_wdata = '0;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;
  logic              host_go = 1'b0;
  logic              addr_err;
  logic [15:0]       wr_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dm_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BUS_W(BUS_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ar_in(ar_in), .bus_in(bus_in), .dm_en(dm_en),
    .end_process(end_process), .dm_out(dm_out), .proc_run(proc_run),
    .host_valid(host_valid), .host_ready(host_ready), .host_wr(host_wr),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .host_go(host_go), .addr_err(addr_err),
    .wr_count(wr_count)
  );

  // Reference model state
  logic [DATA_W-1:0] m_mem [DEPTH];
  bit                m_run, m_ready, m_rvalid, m_err;
  logic [DATA_W-1:0] m_dm_out, m_rdata;
  int unsigned       m_cnt;

  task automatic model_reset();
    m_run = 0; m_ready = 0; m_rvalid = 0; m_err = 0;
    m_dm_out = '0; m_rdata = '0; m_cnt = 0;
  endtask

  // Advance model by one clock using the inputs currently applied, then clock the DUT.
  task automatic cycle();
    int a_p, a_h;
    a_p = int'(ar_in);
    a_h = int'(host_addr);
    m_rvalid = 0;
    if (m_run) begin
      if (a_p < DEPTH) begin
        m_dm_out = m_mem[a_p];
        if (dm_en) begin
          m_mem[a_p] = bus_in[DATA_W-1:0];
          if (m_cnt < 65535) m_cnt++;
        end
      end else begin
        m_dm_out = '0;
        m_err = 1;
      end
      if (end_process) m_run = 0;
    end else begin
      if (host_valid && m_ready) begin
        if (a_h >= DEPTH) m_err = 1;
        if (host_wr) begin
          if (a_h < DEPTH) m_mem[a_h] = host_wdata;
        end else begin
          m_rvalid = 1;
          m_rdata  = (a_h < DEPTH) ? m_mem[a_h] : '0;
        end
      end
      if (host_go) begin
        m_run = 1;
        m_cnt = 0;
      end
    end
    m_ready = !m_run;
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input int a, input logic [DATA_W-1:0] d);
    host_valid = 1; host_wr = 1; host_addr = ADDR_W'(a); host_wdata = d;
    cycle();
    host_valid = 0; host_wr = 0;
  endtask

  task automatic host_read(input int a);
    host_valid = 1; host_wr = 0; host_addr = ADDR_W'(a);
    cycle();
    host_valid = 0;
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    model_reset();
    #10;
    n_checks++; if (dm_out !== 12'h000) begin n_fail++; $display("FAIL rst_dm_out: got %0h want 0", dm_out); end
    n_checks++; if (proc_run !== 1'b0) begin n_fail++; $display("FAIL rst_proc_run: got %0b want 0", proc_run); end
    n_checks++; if (host_ready !== 1'b0) begin n_fail++; $display("FAIL rst_host_ready: got %0b want 0", host_ready); end
    n_checks++; if (host_rdata !== 12'h000) begin n_fail++; $display("FAIL rst_host_rdata: got %0h want 0", host_rdata); end
    n_checks++; if (host_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_host_rvalid: got %0b want 0", host_rvalid); end
    n_checks++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL rst_addr_err: got %0b want 0", addr_err); end
    n_checks++; if (wr_count !== 16'h0000) begin n_fail++; $display("FAIL rst_wr_count: got %0h want 0", wr_count); end
    @(negedge clk);
    rst_n = 1;
    #1;
    n_checks++; if (host_ready !== 1'b0) begin n_fail++; $display("FAIL ready_first_cycle: got %0b want 0", host_ready); end
    cycle();
    n_checks++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_first: got %0b want 1", host_ready); end
    n_checks++; if (proc_run !== 1'b0) begin n_fail++; $display("FAIL idle_proc_run: got %0b want 0", proc_run); end
    n_checks++; if (dm_out !== 12'h000) begin n_fail++; $display("FAIL idle_dm_out: got %0h want 0", dm_out); end
  endtask

  task automatic test_host_rw();
    host_write(3, 12'h0A5);
    host_write(5, 12'h055);
    host_write(7, 12'h077);
    host_write(9, 12'h099);
    host_write(44, 12'h044);
    host_read(3);
    n_checks++; if (host_rvalid !== 1'b1) begin n_fail++; $display("FAIL host_rd_rvalid: got %0b want 1", host_rvalid); end
    n_checks++; if (host_rdata !== 12'h0A5) begin n_fail++; $display("FAIL host_rd_data: got %0h want a5", host_rdata); end
    cycle();
    n_checks++; if (host_rvalid !== 1'b0) begin n_fail++; $display("FAIL host_rvalid_pulse: got %0b want 0", host_rvalid); end
  endtask

  task automatic test_run_read();
    host_go = 1;
    cycle();
    host_go = 0;
    n_checks++; if (proc_run !== 1'b1) begin n_fail++; $display("FAIL go_proc_run: got %0b want 1", proc_run); end
    n_checks++; if (host_ready !== 1'b0) begin n_fail++; $display("FAIL go_host_ready: got %0b want 0", host_ready); end
    ar_in = 12'd3;
    cycle();
    n_checks++; if (dm_out !== 12'h0A5) begin n_fail++; $display("FAIL run_read_3: got %0h want a5", dm_out); end
  endtask

  task automatic test_run_write();
    ar_in = 12'd5; bus_in = 17'h1F123; dm_en = 1;
    cycle();
    dm_en = 0;
    n_checks++; if (dm_out !== 12'h055) begin n_fail++; $display("FAIL read_first_old: got %0h want 55", dm_out); end
    n_checks++; if (wr_count !== 16'd1) begin n_fail++; $display("FAIL wr_count_1: got %0d want 1", wr_count); end
    host_valid = 1; host_wr = 0; host_addr = 12'd3;
    cycle();
    host_valid = 0;
    n_checks++; if (dm_out !== 12'h123) begin n_fail++; $display("FAIL read_new_word: got %0h want 123", dm_out); end
    n_checks++; if (host_rvalid !== 1'b0) begin n_fail++; $display("FAIL host_ignored_in_run: got %0b want 0", host_rvalid); end
  endtask

  task automatic test_end_process();
    ar_in = 12'd7; bus_in = 17'h00456; dm_en = 1; end_process = 1;
    cycle();
    dm_en = 0; end_process = 0;
    n_checks++; if (proc_run !== 1'b0) begin n_fail++; $display("FAIL halt_proc_run: got %0b want 0", proc_run); end
    n_checks++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL halt_host_ready: got %0b want 1", host_ready); end
    n_checks++; if (wr_count !== 16'd2) begin n_fail++; $display("FAIL halt_wr_count: got %0d want 2", wr_count); end
    n_checks++; if (dm_out !== 12'h077) begin n_fail++; $display("FAIL halt_dm_out: got %0h want 77", dm_out); end
    ar_in = 12'd7; bus_in = 17'h00999; dm_en = 1;
    repeat (3) cycle();
    dm_en = 0;
    n_checks++; if (dm_out !== 12'h077) begin n_fail++; $display("FAIL halt_dm_out_hold: got %0h want 77", dm_out); end
    n_checks++; if (wr_count !== 16'd2) begin n_fail++; $display("FAIL halt_no_count: got %0d want 2", wr_count); end
    host_read(7);
    n_checks++; if (host_rdata !== 12'h456) begin n_fail++; $display("FAIL halt_mem7: got %0h want 456", host_rdata); end
  endtask

  task automatic test_addr_err();
    n_checks++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL err_initially: got %0b want 0", addr_err); end
    host_read(300);
    n_checks++; if (host_rvalid !== 1'b1) begin n_fail++; $display("FAIL oor_rvalid: got %0b want 1", host_rvalid); end
    n_checks++; if (host_rdata !== 12'h000) begin n_fail++; $display("FAIL oor_rdata: got %0h want 0", host_rdata); end
    n_checks++; if (addr_err !== 1'b1) begin n_fail++; $display("FAIL oor_err_set: got %0b want 1", addr_err); end
    host_write(300, 12'hBAD);
    host_read(44);
    n_checks++; if (host_rdata !== 12'h044) begin n_fail++; $display("FAIL oor_wr_suppressed: got %0h want 44", host_rdata); end
    host_go = 1;
    cycle();
    host_go = 0;
    ar_in = 12'd300;
    cycle();
    n_checks++; if (dm_out !== 12'h000) begin n_fail++; $display("FAIL oor_proc_read: got %0h want 0", dm_out); end
    ar_in = 12'd10; bus_in = 17'h00111; dm_en = 1;
    cycle();
    dm_en = 0; end_process = 1;
    cycle();
    end_process = 0;
    n_checks++; if (dm_out !== 12'h111) begin n_fail++; $display("FAIL clean_run_read: got %0h want 111", dm_out); end
    n_checks++; if (wr_count !== 16'd1) begin n_fail++; $display("FAIL restart_count: got %0d want 1", wr_count); end
    n_checks++; if (addr_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %0b want 1", addr_err); end
  endtask

  task automatic test_back_to_back();
    host_valid = 1; host_wr = 0;
    host_addr = 12'd3; cycle();
    n_checks++; if (host_rvalid !== 1'b1 || host_rdata !== 12'h0A5) begin n_fail++; $display("FAIL b2b_0: got %0b/%0h want 1/a5", host_rvalid, host_rdata); end
    host_addr = 12'd5; cycle();
    n_checks++; if (host_rvalid !== 1'b1 || host_rdata !== 12'h123) begin n_fail++; $display("FAIL b2b_1: got %0b/%0h want 1/123", host_rvalid, host_rdata); end
    host_addr = 12'd7; cycle();
    n_checks++; if (host_rvalid !== 1'b1 || host_rdata !== 12'h456) begin n_fail++; $display("FAIL b2b_2: got %0b/%0h want 1/456", host_rvalid, host_rdata); end
    host_valid = 0; cycle();
    n_checks++; if (host_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %0b want 0", host_rvalid); end
    host_valid = 1; host_addr = 12'd3; host_go = 1;
    cycle();
    host_valid = 0; host_go = 0;
    n_checks++; if (host_rvalid !== 1'b1 || host_rdata !== 12'h0A5) begin n_fail++; $display("FAIL go_with_read: got %0b/%0h want 1/a5", host_rvalid, host_rdata); end
    n_checks++; if (proc_run !== 1'b1) begin n_fail++; $display("FAIL go_with_read_run: got %0b want 1", proc_run); end
    ar_in = 12'd12; bus_in = 17'h00222; dm_en = 1;
    cycle();
    dm_en = 0; host_go = 1;
    cycle();
    host_go = 0;
    n_checks++; if (host_rvalid !== 1'b0) begin n_fail++; $display("FAIL go_read_single: got %0b want 0", host_rvalid); end
    n_checks++; if (wr_count !== 16'd1 || proc_run !== 1'b1) begin n_fail++; $display("FAIL go_ignored_run: got %0d/%0b want 1/1", wr_count, proc_run); end
    end_process = 1;
    cycle();
    end_process = 0;
  endtask

  task automatic test_reset_midrun();
    host_go = 1; cycle(); host_go = 0;
    ar_in = 12'd9; bus_in = 17'h00333; dm_en = 1; cycle();
    dm_en = 0; ar_in = 12'd3; cycle();
    n_checks++; if (dm_out !== 12'h0A5 || wr_count !== 16'd1) begin n_fail++; $display("FAIL pre_reset: got %0h/%0d want a5/1", dm_out, wr_count); end
    #2 rst_n = 0;
    model_reset();
    #1;
    n_checks++; if (proc_run !== 1'b0) begin n_fail++; $display("FAIL midrun_proc_run: got %0b want 0", proc_run); end
    n_checks++; if (dm_out !== 12'h000) begin n_fail++; $display("FAIL midrun_dm_out: got %0h want 0", dm_out); end
    n_checks++; if (wr_count !== 16'd0) begin n_fail++; $display("FAIL midrun_wr_count: got %0d want 0", wr_count); end
    n_checks++; if (host_rvalid !== 1'b0 || host_ready !== 1'b0 || addr_err !== 1'b0) begin n_fail++; $display("FAIL midrun_ctrl: got %0b/%0b/%0b want 0/0/0", host_rvalid, host_ready, addr_err); end
    @(negedge clk); rst_n = 1;
    cycle();
    host_read(3);
    n_checks++; if (host_rdata !== 12'h0A5) begin n_fail++; $display("FAIL mem_kept: got %0h want a5", host_rdata); end
    #2 rst_n = 0;
    model_reset();
    #1;
    n_checks++; if (host_rvalid !== 1'b0 || host_rdata !== 12'h000) begin n_fail++; $display("FAIL rvalid_discard: got %0b/%0h want 0/0", host_rvalid, host_rdata); end
    @(negedge clk); rst_n = 1;
    cycle();
  endtask

  task automatic test_wr_count_sat();
    host_go = 1; cycle(); host_go = 0;
    ar_in = 12'd10; bus_in = 17'h00ABC; dm_en = 1;
    repeat (65537) cycle();
    dm_en = 0;
    n_checks++; if (wr_count !== 16'hFFFF) begin n_fail++; $display("FAIL wr_count_sat: got %0h want ffff", wr_count); end
    end_process = 1; cycle(); end_process = 0;
    host_go = 1; cycle(); host_go = 0;
    n_checks++; if (wr_count !== 16'h0000) begin n_fail++; $display("FAIL wr_count_clear: got %0h want 0", wr_count); end
    end_process = 1; cycle(); end_process = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < DEPTH; i++) host_write(i, DATA_W'($urandom));
    for (int i = 0; i < 400; i++) begin
      host_valid  = ($urandom_range(0, 1) == 1);
      host_wr     = ($urandom_range(0, 2) == 0);
      host_addr   = ($urandom_range(0, 15) == 0) ? ADDR_W'($urandom_range(DEPTH, 4095)) : ADDR_W'($urandom_range(0, DEPTH - 1));
      host_wdata  = DATA_W'($urandom);
      host_go     = ($urandom_range(0, 9) == 0);
      end_process = ($urandom_range(0, 11) == 0);
      ar_in       = ($urandom_range(0, 19) == 0) ? ADDR_W'($urandom_range(DEPTH, 4095)) : ADDR_W'($urandom_range(0, DEPTH - 1));
      bus_in      = BUS_W'($urandom);
      dm_en       = ($urandom_range(0, 1) == 1);
      cycle();
      n_checks++; if (dm_out !== m_dm_out) begin n_fail++; $display("FAIL rnd_dm_out[%0d]: got %0h want %0h", i, dm_out, m_dm_out); end
      n_checks++; if (proc_run !== m_run) begin n_fail++; $display("FAIL rnd_proc_run[%0d]: got %0b want %0b", i, proc_run, m_run); end
      n_checks++; if (host_ready !== m_ready) begin n_fail++; $display("FAIL rnd_host_ready[%0d]: got %0b want %0b", i, host_ready, m_ready); end
      n_checks++; if (host_rvalid !== m_rvalid) begin n_fail++; $display("FAIL rnd_rvalid[%0d]: got %0b want %0b", i, host_rvalid, m_rvalid); end
      n_checks++; if (host_rdata !== m_rdata) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %0h want %0h", i, host_rdata, m_rdata); end
      n_checks++; if (addr_err !== m_err) begin n_fail++; $display("FAIL rnd_addr_err[%0d]: got %0b want %0b", i, addr_err, m_err); end
      n_checks++; if (wr_count !== 16'(m_cnt)) begin n_fail++; $display("FAIL rnd_wr_count[%0d]: got %0d want %0d", i, wr_count, m_cnt); end
    end
    host_valid = 0; host_wr = 0; host_go = 0; end_process = 0; dm_en = 0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_host_rw();
    test_run_read();
    test_run_write();
    test_end_process();
    test_addr_err();
    test_back_to_back();
    test_reset_midrun();
    test_wr_count_sat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
